// File: rtl/can_frame_decoder.sv
// can_frame_decoder: receive-only classic CAN base-frame parser with CRC-15, form and stuff checks.
module can_frame_decoder #(
  parameter int CLKS_PER_BIT = 10,
  parameter int IDLE_BITS    = 11
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Bit,
  input  logic        i_Bit_Valid,
  input  logic        i_Ignora_Bit,
  input  logic        i_Erro_Flag,
  output logic [10:0] o_Id,
  output logic        o_Rtr,
  output logic [3:0]  o_Dlc,
  output logic [63:0] o_Data,
  output logic        o_Frame_DV,
  output logic        o_Crc_Error,
  output logic        o_Form_Error,
  output logic        o_Busy
);
  typedef enum logic [3:0] {S_WAIT, S_IDLE, S_ID, S_CTRL, S_DATA, S_CRC, S_CDEL, S_ACK, S_ADEL, S_EOF} state_t;
  localparam int TW = $clog2(2*CLKS_PER_BIT+1);
  state_t        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [14:0]   crc_q, crc_d, rxcrc_q, rxcrc_d, crc_nxt;
  logic [10:0]   id_q, id_d;
  logic          rtr_q, rtr_d;
  logic [3:0]    dlc_q, dlc_d;
  logic [63:0]   data_q, data_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          fdv_d, cerr_d, ferr_d, in_scope;
  logic [6:0]    nbits;
  assign o_Busy   = !(state_q inside {S_WAIT, S_IDLE});
  assign in_scope = state_q inside {S_IDLE, S_ID, S_CTRL, S_DATA, S_CRC};
  assign crc_nxt  = {crc_q[13:0], 1'b0} ^ ((i_Bit ^ crc_q[14]) ? 15'h4599 : 15'h0);
  assign nbits    = dlc_q[3] ? 7'd64 : {1'b0, dlc_q[2:0], 3'b000};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    rxcrc_d = rxcrc_q;
    id_d    = id_q;
    rtr_d   = rtr_q;
    dlc_d   = dlc_q;
    data_d  = data_q;
    tmr_d   = (o_Busy && !i_Bit_Valid) ? tmr_q + TW'(1) : '0;
    fdv_d   = 1'b0;
    cerr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (i_Bit_Valid) begin
      if (in_scope && i_Erro_Flag) begin
        ferr_d  = 1'b1;
        state_d = S_WAIT;
        cnt_d   = '0;
      end else if (!(in_scope && i_Ignora_Bit)) begin
        cnt_d = cnt_q + 7'd1;
        case (state_q)
          S_WAIT: begin
            if (!i_Bit) cnt_d = '0;
            else if (cnt_q == 7'(IDLE_BITS-1)) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end
          S_IDLE: begin
            cnt_d = '0;
            if (!i_Bit) begin
              // a dominant SOF folded into a zero CRC leaves it zero
              state_d = S_ID;
              crc_d   = '0;
              data_d  = '0;
            end
          end
          S_ID: begin
            id_d  = {id_q[9:0], i_Bit};
            crc_d = crc_nxt;
            if (cnt_q == 7'd10) begin
              state_d = S_CTRL;
              cnt_d   = '0;
            end
          end
          S_CTRL: begin
            crc_d = crc_nxt;
            if (cnt_q == 7'd0) rtr_d = i_Bit;
            else if (cnt_q == 7'd1 && i_Bit) begin
              ferr_d  = 1'b1;
              state_d = S_WAIT;
              cnt_d   = '0;
            end else if (cnt_q >= 7'd3) dlc_d = {dlc_q[2:0], i_Bit};
            if (cnt_q == 7'd6) begin
              state_d = (rtr_q || dlc_d == 4'd0) ? S_CRC : S_DATA;
              cnt_d   = '0;
            end
          end
          S_DATA: begin
            crc_d = crc_nxt;
            data_d[6'(7'd63 - cnt_q)] = i_Bit;
            if (cnt_q == nbits - 7'd1) begin
              state_d = S_CRC;
              cnt_d   = '0;
            end
          end
          S_CRC: begin
            rxcrc_d = {rxcrc_q[13:0], i_Bit};
            if (cnt_q == 7'd14) begin
              state_d = S_CDEL;
              cnt_d   = '0;
            end
          end
          S_CDEL: begin
            cnt_d   = '0;
            cerr_d  = crc_q != rxcrc_q;
            ferr_d  = crc_q == rxcrc_q && !i_Bit;
            state_d = (cerr_d || ferr_d) ? S_WAIT : S_ACK;
          end
          S_ACK: begin
            cnt_d   = '0;
            state_d = S_ADEL;
          end
          S_ADEL: begin
            cnt_d   = '0;
            ferr_d  = !i_Bit;
            state_d = i_Bit ? S_EOF : S_WAIT;
          end
          S_EOF: begin
            if (!i_Bit) begin
              ferr_d  = 1'b1;
              state_d = S_WAIT;
              cnt_d   = '0;
            end else if (cnt_q == 7'd6) begin
              fdv_d   = 1'b1;
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end
          default: begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        endcase
      end
    end else if (o_Busy && tmr_q == TW'(2*CLKS_PER_BIT-1)) begin
      ferr_d  = 1'b1;
      state_d = S_WAIT;
      cnt_d   = '0;
      tmr_d   = '0;
    end
  end
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= S_WAIT;
      cnt_q        <= '0;
      crc_q        <= '0;
      rxcrc_q      <= '0;
      id_q         <= '0;
      rtr_q        <= 1'b0;
      dlc_q        <= '0;
      data_q       <= '0;
      tmr_q        <= '0;
      o_Id         <= '0;
      o_Rtr        <= 1'b0;
      o_Dlc        <= '0;
      o_Data       <= '0;
      o_Frame_DV   <= 1'b0;
      o_Crc_Error  <= 1'b0;
      o_Form_Error <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      rxcrc_q      <= rxcrc_d;
      id_q         <= id_d;
      rtr_q        <= rtr_d;
      dlc_q        <= dlc_d;
      data_q       <= data_d;
      tmr_q        <= tmr_d;
      o_Frame_DV   <= fdv_d;
      o_Crc_Error  <= cerr_d;
      o_Form_Error <= ferr_d;
      if (fdv_d) begin
        o_Id   <= id_q;
        o_Rtr  <= rtr_q;
        o_Dlc  <= dlc_q;
        o_Data <= data_q;
      end
    end
  end
endmodule

// File: tb/tb_can_frame_decoder.sv
// tb_can_frame_decoder: table-driven frames with a bench CRC/stuffing model and an event scoreboard.
module tb_can_frame_decoder;
  logic        i_Clock = 0, i_Reset_n = 0, i_Bit = 1, i_Bit_Valid = 0, i_Ignora_Bit = 0, i_Erro_Flag = 0;
  logic [10:0] o_Id;
  logic        o_Rtr, o_Frame_DV, o_Crc_Error, o_Form_Error, o_Busy;
  logic [3:0]  o_Dlc;
  logic [63:0] o_Data;
  int checks = 0, passed = 0;

  can_frame_decoder dut (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Bit(i_Bit), .i_Bit_Valid(i_Bit_Valid),
    .i_Ignora_Bit(i_Ignora_Bit), .i_Erro_Flag(i_Erro_Flag), .o_Id(o_Id), .o_Rtr(o_Rtr),
    .o_Dlc(o_Dlc), .o_Data(o_Data), .o_Frame_DV(o_Frame_DV), .o_Crc_Error(o_Crc_Error),
    .o_Form_Error(o_Form_Error), .o_Busy(o_Busy)
  );

  always #5 i_Clock = ~i_Clock;

  // ev encodes {frame_dv, crc_error, form_error}
  typedef struct {logic [2:0] ev; logic [10:0] id; logic rtr; logic [3:0] dlc; logic [63:0] data;} exp_t;
  typedef struct {logic [10:0] id; logic rtr; logic [3:0] dlc; logic [63:0] data; int flip; int err; int idle; logic [2:0] ev; logic [63:0] xdata;} vec_t;
  exp_t sb[$];
  exp_t lg = '{3'b000, 11'h0, 1'b0, 4'h0, 64'h0};
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else passed++;
  endtask

  task automatic send_bit(input logic b, input logic ign, input logic err);
    @(negedge i_Clock);
    i_Bit = b; i_Bit_Valid = 1; i_Ignora_Bit = ign; i_Erro_Flag = err;
    @(negedge i_Clock);
    i_Bit = 1; i_Bit_Valid = 0; i_Ignora_Bit = 0; i_Erro_Flag = 0;
    repeat (2) @(negedge i_Clock);
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1, 0, 0);
  endtask

  task automatic expect_ev(input logic [2:0] ev, input vec_t v);
    exp_t e;
    if (ev == 3'b100) begin
      lg = '{3'b100, v.id, v.rtr, v.dlc, v.xdata};
      sb.push_back(lg);
    end else if (ev != 3'b000) begin
      e = lg;
      e.ev = ev;
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(input vec_t v, input logic push);
    logic raw[$];
    logic [14:0] c;
    logic nx, last, mark;
    int n, run;
    if (push) expect_ev(v.ev, v);
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(v.id[i]);
    raw.push_back(v.rtr); raw.push_back(1'b0); raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(v.dlc[i]);
    n = v.rtr ? 0 : (v.dlc > 8 ? 8 : int'(v.dlc));
    for (int i = 0; i < 8*n; i++) raw.push_back(v.data[63-i]);
    c = '0;
    foreach (raw[i]) begin
      nx = raw[i] ^ c[14];
      c = {c[13:0], 1'b0} ^ (nx ? 15'h4599 : 15'h0);
    end
    for (int i = 14; i >= 0; i--) raw.push_back(c[i] ^ (v.flip == 14 - i));
    last = ~raw[0];
    run = 0;
    foreach (raw[i]) begin
      if (raw[i] == last) run++;
      else begin last = raw[i]; run = 1; end
      mark = v.err >= 0 && i == 19 + v.err;
      send_bit(raw[i], mark, mark);
      if (run == 5 && i != raw.size() - 1) begin
        send_bit(~last, 1, 0);
        last = ~last;
        run = 1;
      end
    end
    send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 0, 0);
    send_ones(7 + v.idle);
  endtask

  always @(negedge i_Clock) begin
    exp_t e;
    if (i_Reset_n && (o_Frame_DV || o_Crc_Error || o_Form_Error)) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_event actual=%b required=none", {o_Frame_DV, o_Crc_Error, o_Form_Error});
      end else begin
        e = sb.pop_front();
        chk("event", {61'h0, o_Frame_DV, o_Crc_Error, o_Form_Error}, {61'h0, e.ev});
        chk("id", {53'h0, o_Id}, {53'h0, e.id});
        chk("rtr", {63'h0, o_Rtr}, {63'h0, e.rtr});
        chk("dlc", {60'h0, o_Dlc}, {60'h0, e.dlc});
        chk("data", o_Data, e.data);
        chk("busy_after_event", {63'h0, o_Busy}, 64'h0);
      end
    end
  end

  initial begin
    vec_t v;
    tbl[0] = '{11'h123, 1'b0, 4'd1,  64'hAA00_0000_0000_0000, -1, -1, 0,  3'b100, 64'hAA00_0000_0000_0000};
    tbl[1] = '{11'h123, 1'b0, 4'd1,  64'hAA00_0000_0000_0000,  3, -1, 11, 3'b010, 64'h0};
    tbl[2] = '{11'h000, 1'b0, 4'd2,  64'hFF00_0000_0000_0000, -1, -1, 0,  3'b100, 64'hFF00_0000_0000_0000};
    tbl[3] = '{11'h555, 1'b0, 4'd4,  64'h1234_5678_0000_0000, -1, 10, 11, 3'b001, 64'h0};
    tbl[4] = '{11'h2AB, 1'b1, 4'd8,  64'hFFFF_FFFF_FFFF_FFFF, -1, -1, 0,  3'b100, 64'h0};
    tbl[5] = '{11'h6A5, 1'b0, 4'd15, 64'h0102_0304_0506_0708, -1, -1, 0,  3'b100, 64'h0102_0304_0506_0708};
    repeat (3) @(negedge i_Clock);
    chk("rst_id", {53'h0, o_Id}, 64'h0);
    chk("rst_data", o_Data, 64'h0);
    chk("rst_busy", {63'h0, o_Busy}, 64'h0);
    chk("rst_pulses", {61'h0, o_Frame_DV, o_Crc_Error, o_Form_Error}, 64'h0);
    i_Reset_n = 1;
    send_ones(11);
    for (int k = 0; k < 6; k++) send_frame(tbl[k], 1);
    send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(0, 0, 0);
    chk("busy_mid_id", {63'h0, o_Busy}, 64'h1);
    @(negedge i_Clock);
    i_Reset_n = 0;
    #1;
    chk("midrst_id", {53'h0, o_Id}, 64'h0);
    chk("midrst_dlc", {60'h0, o_Dlc}, 64'h0);
    chk("midrst_data", o_Data, 64'h0);
    chk("midrst_rtr_busy", {62'h0, o_Rtr, o_Busy}, 64'h0);
    lg = '{3'b000, 11'h0, 1'b0, 4'h0, 64'h0};
    @(negedge i_Clock);
    i_Reset_n = 1;
    send_bit(0, 0, 0);
    chk("sof_before_integration", {63'h0, o_Busy}, 64'h0);
    send_ones(14);
    send_frame(tbl[0], 1);
    send_bit(0, 0, 0); send_bit(1, 0, 0);
    expect_ev(3'b001, tbl[0]);
    repeat (30) @(negedge i_Clock);
    chk("busy_after_timeout", {63'h0, o_Busy}, 64'h0);
    send_ones(11);
    v = tbl[2];
    send_frame(v, 1);
    repeat (10) @(negedge i_Clock);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
